mux4_rr_arbiter: RTL and testbench

- Shares one 4:1 data mux (selects s1,s0) among four requesters using round-robin arbitration and a valid/ready handshake on each input and on the output.
- Generates the mux select, an out_valid/out_ready output stage and per-requester in_ready.
- Sits in front of the 4:1 mux datapath; that datapath is instantiated inside this block and driven only by the registered grant.

---
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter in front of a shared 4:1 data mux, with a valid/ready
// handshake on every requester and on the registered output stage.
//
// Optional feature macro: MUX4_ARB_LOCK_EN
//   defined   : adds in_last; the grant is held across accepts (burst lock)
//               until in_last or the MAX_BURST-th accept of the grant.
//   undefined : every accepted beat releases the grant.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-requester valid (bit k = requester k)
//   in_data    packed requester data, requester k at [k*WIDTH +: WIDTH]
//   in_ready   one-hot-or-zero acceptance, only for the granted requester
//   in_last    burst end per requester (MUX4_ARB_LOCK_EN only)
//   out_valid  out_data holds a beat
//   out_data   registered mux output
//   out_ready  downstream accepts the beat
//   s0, s1     mux select, straight from the registered grant
//   busy       high while in GRANT
//
// state | meaning
// IDLE  | no grant; winner of the round-robin scan is registered next edge
// GRANT | grant valid; granted requester may hand over beats

module mux4_rr_arbiter #(
   parameter int WIDTH     = 1,
   parameter int MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         in_ready,
`ifdef MUX4_ARB_LOCK_EN
   input  logic [3:0]         in_last,
`endif
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready,
   output logic               s0,
   output logic               s1,
   output logic               busy
);

   if (MAX_BURST < 1) begin : g_bad_burst
      $error("mux4_rr_arbiter: MAX_BURST must be >= 1");
   end

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] grant, grant_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [1:0] winner;
   logic       found;
   logic       rdy;
   logic       accept;
   logic       last_beat;
   logic [WIDTH-1:0] mux_data;

`ifdef MUX4_ARB_LOCK_EN
   localparam int CW = $clog2(MAX_BURST + 1);
   logic [CW-1:0] beat_cnt, beat_cnt_nxt;
   assign last_beat = in_last[grant] | (beat_cnt == CW'(MAX_BURST - 1));
`else
   assign last_beat = 1'b1;
`endif

   // The shared datapath only ever sees the registered grant.
   assign mux_data = in_data[int'(grant)*WIDTH +: WIDTH];

   assign s0   = grant[0];
   assign s1   = grant[1];
   assign busy = (state == GRANT);

   // First valid requester at or after the pointer, wrapping mod 4.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] idx;
         idx = ptr + 2'(i);
         if (!found && in_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Ready only looks at the output stage, never at in_valid.
   assign rdy = ~out_valid | out_ready;

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      in_ready  = 4'b0000;
      accept    = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
      beat_cnt_nxt = '0;
`endif
      case (state)
         IDLE: begin
            if (|in_valid) begin
               state_nxt = GRANT;
               grant_nxt = winner;
            end
         end
         GRANT: begin
            in_ready[grant] = rdy;
            accept          = in_valid[grant] & rdy;
            if (!in_valid[grant]) begin
               state_nxt = IDLE;
            end else if (accept && last_beat) begin
               state_nxt = IDLE;
               ptr_nxt   = grant + 2'd1;
            end
`ifdef MUX4_ARB_LOCK_EN
            else if (accept) begin
               beat_cnt_nxt = beat_cnt + CW'(1);
            end else begin
               beat_cnt_nxt = beat_cnt;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 2'd0;
         ptr       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef MUX4_ARB_LOCK_EN
         beat_cnt  <= '0;
`endif
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
`ifdef MUX4_ARB_LOCK_EN
         beat_cnt <= beat_cnt_nxt;
`endif
         // A new beat wins over a drain in the same cycle.
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

   localparam int WIDTH = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         in_valid;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_ready;
   logic [3:0]         in_last;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic               out_ready;
   logic               s0, s1, busy;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] sb_q[$];

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
`ifdef MUX4_ARB_LOCK_EN
      .in_last   (in_last),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .s0        (s0),
      .s1        (s1),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nxt();
      rst = 1'b0;
   endtask

   // Output monitor: every completed output handshake pops the scoreboard.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) chk("beat_data", 32'(out_data), 32'(sb_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
      nxt(); nxt();
      mid();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_sel", 32'({s1, s0}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      nxt();
      rst = 1'b0;

      // Single request latency
      in_valid = 4'b0001; in_data = {4'hD, 4'hC, 4'hB, 4'h1}; out_ready = 1'b1;
      sb_q.push_back(4'h1);
      mid();
      chk("t1_c0_in_ready", 32'(in_ready), 32'd0);
      nxt();
      mid();
      chk("t1_c1_sel", 32'({s1, s0}), 32'd0);
      chk("t1_c1_in_ready", 32'(in_ready), 32'b0001);
      chk("t1_c1_out_valid", 32'(out_valid), 32'd0);
      nxt();
      in_valid = 4'b0000;
      mid();
      chk("t1_c2_out_valid", 32'(out_valid), 32'd1);
      chk("t1_c2_out_data", 32'(out_data), 32'h1);
      chk("t1_c2_busy", 32'(busy), 32'd0);
      nxt();

      // Full rotation with all requesters active
      do_reset();
      in_valid = 4'b1111; in_data = {4'h8, 4'h7, 4'h6, 4'h5};
      for (int r = 0; r < 5; r++) begin
         sb_q.push_back(4'(5 + (r % 4)));
         nxt();
         mid();
         chk("t2_sel", 32'({s1, s0}), 32'(r % 4));
         chk("t2_in_ready", 32'(in_ready), 32'(1 << (r % 4)));
         nxt();
      end
      in_valid = 4'b0000;
      nxt(); nxt();

      // Back-pressure, then drain and accept in the same cycle
      do_reset();
      out_ready = 1'b0; in_valid = 4'b0011; in_data = {4'h0, 4'h0, 4'h6, 4'h5};
      sb_q.push_back(4'h5);
      nxt();
      mid();
      chk("t3_c1_in_ready", 32'(in_ready), 32'b0001);
      nxt();
      mid();
      chk("t3_c2_out_data", 32'(out_data), 32'h5);
      nxt();
      mid();
      chk("t3_c3_stall_ready", 32'(in_ready), 32'd0);
      chk("t3_c3_sel", 32'({s1, s0}), 32'd1);
      nxt();
      mid();
      chk("t3_c4_stall_ready", 32'(in_ready), 32'd0);
      chk("t3_c4_hold_data", 32'(out_data), 32'h5);
      chk("t3_c4_hold_valid", 32'(out_valid), 32'd1);
      nxt();
      out_ready = 1'b1;
      sb_q.push_back(4'h6);
      mid();
      chk("t3_c5_in_ready", 32'(in_ready), 32'b0010);
      nxt();
      in_valid = 4'b0000;
      mid();
      chk("t3_c6_out_valid", 32'(out_valid), 32'd1);
      chk("t3_c6_out_data", 32'(out_data), 32'h6);
      nxt(); nxt();

      // Dropped request leaves the pointer alone
      do_reset();
      in_valid = 4'b0010; in_data = {4'hB, 4'hA, 4'h9, 4'h0};
      sb_q.push_back(4'h9);
      nxt(); nxt();
      in_valid = 4'b0100;
      nxt();
      in_valid = 4'b0000;
      mid();
      chk("t4_grant2_sel", 32'({s1, s0}), 32'd2);
      chk("t4_grant2_busy", 32'(busy), 32'd1);
      chk("t4_grant2_ready", 32'(in_ready), 32'b0100);
      nxt();
      in_valid = 4'b1100;
      sb_q.push_back(4'hA);
      mid();
      chk("t4_drop_busy", 32'(busy), 32'd0);
      chk("t4_drop_out_valid", 32'(out_valid), 32'd0);
      nxt();
      mid();
      chk("t4_rereq_sel", 32'({s1, s0}), 32'd2);
      nxt();
      in_valid = 4'b0000;
      mid();
      chk("t4_rereq_data", 32'(out_data), 32'hA);
      nxt(); nxt();

      // Reset while a beat is held and a grant is active
      do_reset();
      out_ready = 1'b0; in_valid = 4'b0011; in_data = {4'h0, 4'h0, 4'h4, 4'h3};
      nxt(); nxt(); nxt();
      rst = 1'b1; in_valid = 4'b0000;
      mid();
      chk("t5_pre_out_valid", 32'(out_valid), 32'd1);
      chk("t5_pre_busy", 32'(busy), 32'd1);
      nxt();
      rst = 1'b0;
      mid();
      chk("t5_post_out_valid", 32'(out_valid), 32'd0);
      chk("t5_post_out_data", 32'(out_data), 32'd0);
      chk("t5_post_busy", 32'(busy), 32'd0);
      chk("t5_post_sel", 32'({s1, s0}), 32'd0);
      chk("t5_post_in_ready", 32'(in_ready), 32'd0);
      in_valid = 4'b0011; in_data = {4'h0, 4'h0, 4'hF, 4'hE}; out_ready = 1'b1;
      sb_q.push_back(4'hE);
      nxt();
      mid();
      chk("t5_ptr0_sel", 32'({s1, s0}), 32'd0);
      nxt();
      in_valid = 4'b0000;
      nxt(); nxt();

`ifdef MUX4_ARB_LOCK_EN
      // Burst capped at MAX_BURST, then the next requester
      do_reset();
      in_valid = 4'b1010; in_last = 4'b0000; in_data = {4'h3, 4'h0, 4'h1, 4'h0};
      for (int b = 0; b < 4; b++) sb_q.push_back(4'h1);
      sb_q.push_back(4'h3);
      for (int c = 1; c <= 4; c++) begin
         nxt();
         mid();
         chk("t6_burst_sel", 32'({s1, s0}), 32'd1);
         chk("t6_burst_ready", 32'(in_ready), 32'b0010);
      end
      nxt();
      mid();
      chk("t6_release_busy", 32'(busy), 32'd0);
      nxt();
      mid();
      chk("t6_next_sel", 32'({s1, s0}), 32'd3);
      nxt();
      in_valid = 4'b0000;
      nxt(); nxt();

      // in_last ends the burst early
      do_reset();
      in_valid = 4'b0010; in_last = 4'b0000; in_data = {4'h0, 4'h0, 4'h5, 4'h0};
      sb_q.push_back(4'h5);
      sb_q.push_back(4'h5);
      nxt();
      mid();
      chk("t7_beat1_ready", 32'(in_ready), 32'b0010);
      nxt();
      in_last = 4'b0010;
      mid();
      chk("t7_beat2_ready", 32'(in_ready), 32'b0010);
      nxt();
      in_valid = 4'b0000; in_last = 4'b0000;
      mid();
      chk("t7_release_busy", 32'(busy), 32'd0);
      nxt(); nxt();
`endif

      nxt(); nxt();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
